// File: rtl/data_mem_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : data_mem_unit
// Description : Load/store responder with byte/half/word lanes, sign/zero
//               extension, WAIT_CYC wait states, flush and error rejection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module data_mem_unit #(
   parameter int DEPTH    = 1024,
   parameter int WAIT_CYC = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_dat_in,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic [1:0]  mem_size_in,
   input  logic        mem_unsigned,
   input  logic        flush_in,
   output logic [31:0] ld_dat_out,
   output logic        ld_valid,
   output logic        st_done,
   output logic        err_out,
   output logic        stall_out
);

   localparam int         c_aw   = $clog2(DEPTH);
   localparam logic [3:0] c_wait = 4'(WAIT_CYC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;

   logic [c_aw+1:0] r_addr;
   logic [31:0]     r_wdata;
   logic            r_is_load;
   logic [1:0]      r_size;
   logic            r_unsigned;

   logic [31:0]     r_mem [DEPTH];

   logic [31:0]     r_ld_dat;
   logic            r_ld_valid;
   logic            r_st_done;
   logic            r_err;
   logic            r_stall;

   logic            w_req;
   logic            w_can_accept;
   logic            w_illegal;
   logic            w_accept;
   logic            w_reject;
   logic            w_busy_fire;
   logic            w_do_access;

   logic [c_aw+1:0] w_acc_addr;
   logic [c_aw-1:0] w_acc_idx;
   logic [31:0]     w_acc_wdata;
   logic            w_acc_load;
   logic [1:0]      w_acc_size;
   logic            w_acc_uns;

   logic [3:0]      w_be;
   logic [31:0]     w_wlane;
   logic [31:0]     w_rd_word;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_ld_ext;
   logic            w_addr_unused;

   assign w_addr_unused = ^mem_addr_in[31:c_aw+2];

   assign w_req        = mem_read_en | mem_write_en;
   assign w_can_accept = (r_state != S_BUSY) && w_req && !flush_in;
   assign w_illegal    = (mem_read_en & mem_write_en)
                       | (mem_size_in == 2'b11)
                       | ((mem_size_in == 2'b01) & mem_addr_in[0])
                       | ((mem_size_in == 2'b10) & (mem_addr_in[1:0] != 2'b00));
   assign w_accept     = w_can_accept && !w_illegal;
   assign w_reject     = w_can_accept && w_illegal;
   assign w_busy_fire  = (r_state == S_BUSY) && !flush_in && (r_cnt == 4'd1);
   // Zero-wait accesses happen on the accept edge using live inputs.
   assign w_do_access  = (c_wait == 4'd0) ? w_accept : w_busy_fire;

   assign w_acc_addr  = (r_state == S_BUSY) ? r_addr     : mem_addr_in[c_aw+1:0];
   assign w_acc_wdata = (r_state == S_BUSY) ? r_wdata    : mem_dat_in;
   assign w_acc_load  = (r_state == S_BUSY) ? r_is_load  : mem_read_en;
   assign w_acc_size  = (r_state == S_BUSY) ? r_size     : mem_size_in;
   assign w_acc_uns   = (r_state == S_BUSY) ? r_unsigned : mem_unsigned;
   assign w_acc_idx   = w_acc_addr[c_aw+1:2];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               if (c_wait == 4'd0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = c_wait;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (flush_in) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_is_load  <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_ld_dat   <= 32'd0;
         r_ld_valid <= 1'b0;
         r_st_done  <= 1'b0;
         r_err      <= 1'b0;
         r_stall    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ld_valid <= w_do_access & w_acc_load;
         r_st_done  <= w_do_access & !w_acc_load;
         r_err      <= w_reject;
         r_stall    <= (w_state_nxt == S_BUSY);
         if (w_accept) begin
            r_addr     <= mem_addr_in[c_aw+1:0];
            r_wdata    <= mem_dat_in;
            r_is_load  <= mem_read_en;
            r_size     <= mem_size_in;
            r_unsigned <= mem_unsigned;
         end
         if (w_do_access && w_acc_load) begin
            r_ld_dat <= w_ld_ext;
         end
      end
   end

   // Narrow stores replicate the datum across lanes; the byte enables pick one.
   always_comb begin
      w_be    = 4'b1111;
      w_wlane = w_acc_wdata;
      case (w_acc_size)
         2'b00: begin
            w_be    = 4'b0001 << w_acc_addr[1:0];
            w_wlane = {4{w_acc_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_acc_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wlane = w_acc_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_do_access && !w_acc_load) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_acc_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
         end
      end
   end

   assign w_rd_word = r_mem[w_acc_idx];

   always_comb begin
      w_byte   = w_rd_word[7:0];
      w_half   = w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      w_ld_ext = w_rd_word;
      case (w_acc_addr[1:0])
         2'b00:   w_byte = w_rd_word[7:0];
         2'b01:   w_byte = w_rd_word[15:8];
         2'b10:   w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      case (w_acc_size)
         2'b00:   w_ld_ext = w_acc_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_ld_ext = w_acc_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ld_ext = w_rd_word;
      endcase
   end

   assign ld_dat_out = r_ld_dat;
   assign ld_valid   = r_ld_valid;
   assign st_done    = r_st_done;
   assign err_out    = r_err;
   assign stall_out  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_data_mem_unit
// Description : Bench for data_mem_unit; zero-wait and 3-wait instances
//               checked against a byte-addressed reference memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_data_mem_unit;

   localparam int DEPTH = 64;
   localparam int NBYTE = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr_i [2];
   logic [31:0] dat_i [2];
   logic        rd_i [2];
   logic        wr_i [2];
   logic [1:0]  size_i [2];
   logic        uns_i [2];
   logic        flush_i [2];
   logic [31:0] ld_dat_o [2];
   logic        ld_valid_o [2];
   logic        st_done_o [2];
   logic        err_o [2];
   logic        stall_o [2];

   logic [7:0]  mdl [2][NBYTE];
   logic [31:0] last_ld [2];
   int          wait_of [2] = '{0, 3};
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_addr_in(addr_i[0]), .mem_dat_in(dat_i[0]),
      .mem_read_en(rd_i[0]), .mem_write_en(wr_i[0]), .mem_size_in(size_i[0]),
      .mem_unsigned(uns_i[0]), .flush_in(flush_i[0]), .ld_dat_out(ld_dat_o[0]),
      .ld_valid(ld_valid_o[0]), .st_done(st_done_o[0]), .err_out(err_o[0]),
      .stall_out(stall_o[0]));

   data_mem_unit #(.DEPTH(DEPTH), .WAIT_CYC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mem_addr_in(addr_i[1]), .mem_dat_in(dat_i[1]),
      .mem_read_en(rd_i[1]), .mem_write_en(wr_i[1]), .mem_size_in(size_i[1]),
      .mem_unsigned(uns_i[1]), .flush_in(flush_i[1]), .ld_dat_out(ld_dat_o[1]),
      .ld_valid(ld_valid_o[1]), .st_done(st_done_o[1]), .err_out(err_o[1]),
      .stall_out(stall_o[1]));

   // Reference model: flat little-endian byte memory, wraps modulo its size.
   function automatic bit m_legal(input logic ld, input logic st, input logic [31:0] a,
                                  input logic [1:0] sz);
      if (ld && st) return 1'b0;
      if (sz == 2'd3) return 1'b0;
      if ((a % (32'd1 << sz)) != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_store(input int sel, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz);
      int base = int'(a % NBYTE);
      for (int i = 0; i < (1 << sz); i++) mdl[sel][base + i] = d[8*i +: 8];
   endtask

   function automatic logic [31:0] m_load(input int sel, input logic [31:0] a,
                                          input logic [1:0] sz, input logic u);
      int base = int'(a % NBYTE);
      int nb = 1 << sz;
      logic [31:0] v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mdl[sel][base + i]) << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      return v;
   endfunction

   // Drives one request and records what the DUT does over ncyc cycles after accept edge.
   task automatic xact(input int sel, input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u, input int ncyc,
                       output logic [31:0] dat_seen, output int n_ld, output int n_st,
                       output int n_err, output int n_stall, output int first);
      @(negedge clk);
      addr_i[sel] = a; dat_i[sel] = d; rd_i[sel] = ld; wr_i[sel] = st;
      size_i[sel] = sz; uns_i[sel] = u;
      n_ld = 0; n_st = 0; n_err = 0; n_stall = 0; first = 0; dat_seen = 32'd0;
      @(posedge clk); #1;
      rd_i[sel] = 1'b0; wr_i[sel] = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (ld_valid_o[sel]) begin n_ld++; dat_seen = ld_dat_o[sel]; if (first == 0) first = c; end
         if (st_done_o[sel]) begin n_st++; if (first == 0) first = c; end
         if (err_o[sel]) begin n_err++; if (first == 0) first = c; end
         if (stall_o[sel]) n_stall++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         addr_i[s] = 0; dat_i[s] = 0; rd_i[s] = 0; wr_i[s] = 0;
         size_i[s] = 0; uns_i[s] = 0; flush_i[s] = 0; last_ld[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({ld_dat_o[s], ld_valid_o[s], st_done_o[s], err_o[s], stall_o[s]} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got dat=%h v=%b d=%b e=%b s=%b, want all 0",
                     s, ld_dat_o[s], ld_valid_o[s], st_done_o[s], err_o[s], stall_o[s]);
         end
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_init();
      logic [31:0] ds, d;
      int nl, ns, ne, nst, fp;
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            xact(s, 1'b0, 1'b1, 32'(4 * w), d, 2'd2, 1'b0, wait_of[s] + 2, ds, nl, ns, ne, nst, fp);
            m_store(s, 32'(4 * w), d, 2'd2);
            checks++;
            if (ns != 1 || fp != wait_of[s] + 1 || nst != wait_of[s]) begin
               errors++;
               $display("FAIL init_store dut%0d w%0d: st_done=%0d at %0d stall=%0d, want 1 at %0d stall=%0d",
                        s, w, ns, fp, nst, wait_of[s] + 1, wait_of[s]);
            end
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] ds;
      int nl, ns, ne, nst, fp;
      logic [31:0] exp_v [4] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF};
      xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 2, ds, nl, ns, ne, nst, fp);
      m_store(0, 32'h10, 32'hDEADBEEF, 2'd2);
      checks++;
      if (ns != 1 || fp != 1) begin
         errors++; $display("FAIL sw_done: st_done=%0d at %0d, want 1 at 1", ns, fp);
      end
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            xact(0, 1'b0, 1'b1, 32'h13, 32'hABCD1280, 2'd0, 1'b0, 2, ds, nl, ns, ne, nst, fp);
            m_store(0, 32'h13, 32'hABCD1280, 2'd0);
         end
         xact(0, 1'b1, 1'b0, (k == 0 || k == 3) ? 32'h10 : 32'h13, 32'd0,
              (k == 0 || k == 3) ? 2'd2 : 2'd0, k == 2, 2, ds, nl, ns, ne, nst, fp);
         last_ld[0] = exp_v[k];
         checks++;
         if (nl != 1 || fp != 1 || ds !== exp_v[k]) begin
            errors++;
            $display("FAIL directed_load%0d: ld_valid=%0d at %0d data=%h, want 1 at 1 data=%h",
                     k, nl, fp, ds, exp_v[k]);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] ds;
      int nl, ns, ne, nst, fp;
      logic [31:0] ea [4] = '{32'h11, 32'h12, 32'h10, 32'h10};
      logic [1:0]  es [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
      logic        ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 4; k++) begin
            xact(s, 1'b1, ew[k], ea[k], 32'h55AA55AA, es[k], 1'b0, wait_of[s] + 3,
                 ds, nl, ns, ne, nst, fp);
            checks++;
            if (ne != 1 || fp != 1 || nl != 0 || ns != 0 || nst != 0) begin
               errors++;
               $display("FAIL reject%0d dut%0d: err=%0d at %0d ld=%0d st=%0d stall=%0d, want err 1 at 1 others 0",
                        k, s, ne, fp, nl, ns, nst);
            end
         end
         xact(s, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, wait_of[s] + 2, ds, nl, ns, ne, nst, fp);
         last_ld[s] = m_load(s, 32'h10, 2'd2, 1'b0);
         checks++;
         if (nl != 1 || ds !== last_ld[s]) begin
            errors++;
            $display("FAIL reject_mem_intact dut%0d: data=%h, want %h", s, ds, last_ld[s]);
         end
      end
   endtask

   task automatic test_alias();
      logic [31:0] ds;
      int nl, ns, ne, nst, fp;
      xact(0, 1'b0, 1'b1, 32'h10 + 4 * DEPTH, 32'hCAFEF00D, 2'd2, 1'b0, 2, ds, nl, ns, ne, nst, fp);
      xact(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 2, ds, nl, ns, ne, nst, fp);
      m_store(0, 32'h10, 32'hCAFEF00D, 2'd2);
      last_ld[0] = 32'hCAFEF00D;
      checks++;
      if (nl != 1 || ds !== 32'hCAFEF00D) begin
         errors++; $display("FAIL alias_word4: data=%h, want cafef00d", ds);
      end
   endtask

   task automatic test_random(input int sel, input int n);
      logic [31:0] a, d, ds, exp_d;
      logic [1:0]  sz;
      logic        ld, st, u, legal;
      int nl, ns, ne, nst, fp, op, lat;
      lat = wait_of[sel] + 1;
      for (int k = 0; k < n; k++) begin
         sz = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         op = $urandom_range(0, 9);
         ld = (op <= 4); st = (op == 0) || (op >= 5);
         d = $urandom; u = 1'($urandom_range(0, 1));
         legal = m_legal(ld, st, a, sz);
         xact(sel, ld, st, a, d, sz, u, wait_of[sel] + 3, ds, nl, ns, ne, nst, fp);
         checks++;
         if (legal && ld) begin
            exp_d = m_load(sel, a, sz, u);
            last_ld[sel] = exp_d;
            if (nl != 1 || ns != 0 || ne != 0 || fp != lat || ds !== exp_d) begin
               errors++;
               $display("FAIL rand_load dut%0d a=%h sz=%0d u=%b: ld=%0d st=%0d err=%0d at %0d data=%h, want ld 1 at %0d data=%h",
                        sel, a, sz, u, nl, ns, ne, fp, ds, lat, exp_d);
            end
         end else if (legal) begin
            m_store(sel, a, d, sz);
            if (ns != 1 || nl != 0 || ne != 0 || fp != lat) begin
               errors++;
               $display("FAIL rand_store dut%0d a=%h sz=%0d: st=%0d ld=%0d err=%0d at %0d, want st 1 at %0d",
                        sel, a, sz, ns, nl, ne, fp, lat);
            end
         end else begin
            if (ne != 1 || nl != 0 || ns != 0 || fp != 1) begin
               errors++;
               $display("FAIL rand_reject dut%0d a=%h sz=%0d rd=%b wr=%b: err=%0d ld=%0d st=%0d at %0d, want err 1 at 1",
                        sel, a, sz, ld, st, ne, nl, ns, fp);
            end
         end
         checks++;
         if (nst != (legal ? wait_of[sel] : 0) || ld_dat_o[sel] !== last_ld[sel]) begin
            errors++;
            $display("FAIL rand_stall_hold dut%0d: stall=%0d hold=%h, want stall=%0d hold=%h",
                     sel, nst, ld_dat_o[sel], legal ? wait_of[sel] : 0, last_ld[sel]);
         end
      end
   endtask

   task automatic test_wait_busy_ignore();
      logic [31:0] exp_d, ds;
      int nl, ns, ne, nst, fp;
      exp_d = m_load(1, 32'h20, 2'd2, 1'b0);
      @(negedge clk);
      addr_i[1] = 32'h20; rd_i[1] = 1'b1; wr_i[1] = 1'b0; size_i[1] = 2'd2; uns_i[1] = 1'b0;
      @(posedge clk); #1;
      rd_i[1] = 1'b0; wr_i[1] = 1'b1; dat_i[1] = ~exp_d;
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (c == 3) wr_i[1] = 1'b0;
         checks++;
         if (stall_o[1] !== 1'b1 || ld_valid_o[1] !== 1'b0 || st_done_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycle%0d: stall=%b ld=%b st=%b, want 1 0 0",
                     c, stall_o[1], ld_valid_o[1], st_done_o[1]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ld_valid_o[1] !== 1'b1 || ld_dat_o[1] !== exp_d || stall_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL busy_done: ld=%b data=%h stall=%b, want 1 %h 0",
                  ld_valid_o[1], ld_dat_o[1], stall_o[1], exp_d);
      end
      @(posedge clk); #1;
      checks++;
      if (ld_valid_o[1] !== 1'b0 || st_done_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL busy_after: ld=%b st=%b, want 0 0", ld_valid_o[1], st_done_o[1]);
      end
      xact(1, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 5, ds, nl, ns, ne, nst, fp);
      last_ld[1] = exp_d;
      checks++;
      if (ds !== exp_d) begin
         errors++; $display("FAIL busy_store_ignored: data=%h, want %h", ds, exp_d);
      end
   endtask

   task automatic test_flush();
      logic [31:0] ds, exp_d;
      int nl, ns, ne, nst, fp, seen;
      @(negedge clk);
      addr_i[1] = 32'h20; dat_i[1] = 32'h1234; wr_i[1] = 1'b1; size_i[1] = 2'd2;
      @(posedge clk); #1;
      wr_i[1] = 1'b0;
      @(negedge clk) flush_i[1] = 1'b1;
      @(posedge clk); #1;
      flush_i[1] = 1'b0;
      seen = int'(stall_o[1]);
      repeat (4) begin
         @(posedge clk); #1;
         seen += int'(st_done_o[1]) + int'(stall_o[1]);
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL flush_busy: stall/st_done events=%0d, want 0", seen);
      end
      exp_d = m_load(1, 32'h20, 2'd2, 1'b0);
      xact(1, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 5, ds, nl, ns, ne, nst, fp);
      last_ld[1] = exp_d;
      checks++;
      if (ds !== exp_d) begin
         errors++; $display("FAIL flush_no_write: data=%h, want %h", ds, exp_d);
      end
      @(negedge clk);
      addr_i[0] = 32'h30; dat_i[0] = 32'h0BADC0DE; wr_i[0] = 1'b1; size_i[0] = 2'd2;
      flush_i[0] = 1'b1;
      @(posedge clk); #1;
      wr_i[0] = 1'b0; flush_i[0] = 1'b0;
      checks++;
      if (st_done_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
         errors++; $display("FAIL flush_idle: st=%b err=%b, want 0 0", st_done_o[0], err_o[0]);
      end
      exp_d = m_load(0, 32'h30, 2'd2, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 2, ds, nl, ns, ne, nst, fp);
      last_ld[0] = exp_d;
      checks++;
      if (ds !== exp_d) begin
         errors++; $display("FAIL flush_idle_mem: data=%h, want %h", ds, exp_d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ds, exp_d;
      int nl, ns, ne, nst, fp;
      @(negedge clk);
      addr_i[1] = 32'h24; dat_i[1] = 32'h00005678; wr_i[1] = 1'b1; size_i[1] = 2'd2;
      @(posedge clk); #1;
      wr_i[1] = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      #1;
      checks++;
      if ({ld_dat_o[1], ld_valid_o[1], st_done_o[1], err_o[1], stall_o[1]} !== 36'd0 ||
          ld_dat_o[0] !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: dat=%h st=%b stall=%b dat0=%h, want all 0",
                  ld_dat_o[1], st_done_o[1], stall_o[1], ld_dat_o[0]);
      end
      @(negedge clk) rst_n = 1'b1;
      last_ld[0] = 32'd0; last_ld[1] = 32'd0;
      exp_d = m_load(1, 32'h24, 2'd2, 1'b0);
      xact(1, 1'b1, 1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 5, ds, nl, ns, ne, nst, fp);
      last_ld[1] = exp_d;
      checks++;
      if (nl != 1 || ds !== exp_d) begin
         errors++; $display("FAIL reset_discard: ld=%0d data=%h, want 1 %h", nl, ds, exp_d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      d = $urandom;
      @(negedge clk);
      addr_i[0] = 32'h40; dat_i[0] = d; wr_i[0] = 1'b1; rd_i[0] = 1'b0; size_i[0] = 2'd2;
      @(posedge clk); #1;
      checks++;
      if (st_done_o[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_store: st_done=%b, want 1", st_done_o[0]);
      end
      wr_i[0] = 1'b0; rd_i[0] = 1'b1;
      @(posedge clk); #1;
      rd_i[0] = 1'b0;
      m_store(0, 32'h40, d, 2'd2);
      last_ld[0] = d;
      checks++;
      if (ld_valid_o[0] !== 1'b1 || st_done_o[0] !== 1'b0 || ld_dat_o[0] !== d) begin
         errors++;
         $display("FAIL b2b_load: ld=%b st=%b data=%h, want 1 0 %h",
                  ld_valid_o[0], st_done_o[0], ld_dat_o[0], d);
      end
      @(posedge clk); #1;
      checks++;
      if (ld_valid_o[0] !== 1'b0) begin
         errors++; $display("FAIL b2b_pulse_width: ld=%b, want 0", ld_valid_o[0]);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_directed();
      test_errors();
      test_alias();
      test_random(0, 200);
      test_wait_busy_ignore();
      test_random(1, 60);
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
